// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//
// Runtime-programmable serial sequence detector. A pattern of 1..MAX_W bits
// is matched against a qualified serial stream. Overlapping and
// non-overlapping matching are both supported. Every match is counted in a
// saturating counter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (asserted when 0)
//   ser_in     serial data bit
//   ser_valid  ser_in is sampled only when this is 1
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   pat_load   one-cycle strobe that loads pat_in/len_in
//   pat_in     new pattern; bit len-1 is the first bit received, bit 0 the last
//   len_in     new pattern length (values above MAX_W are clamped to MAX_W)
//   cnt_clr    synchronous clear of match_cnt
//   det_out    registered one-cycle match pulse
//   match_cnt  saturating number of matches
//   cnt_sat    high while match_cnt is all ones
//   armed      history holds at least len valid bits, so a match is possible
// ---------------------------------------------------------------------------
module seq_det_prog #(
  parameter int                 MAX_W   = 16,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_W-1:0]   DEF_PAT = 16'h0EDB,
  parameter int                 DEF_LEN = 12,
  localparam int                LW      = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [MAX_W-1:0] pat_in,
  input  logic [LW-1:0]    len_in,
  input  logic             cnt_clr,
  output logic             det_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  logic [MAX_W-1:0] hist;
  logic [LW-1:0]    fill;
  logic [MAX_W-1:0] pat;
  logic [LW-1:0]    len;

  logic [MAX_W-1:0] next_hist;
  logic [LW-1:0]    next_fill;
  logic [MAX_W-1:0] len_mask;
  logic             match;

  // The match is judged on the history as it will look after this edge's
  // shift. Only the low len bits are compared. The fill gate stops stale
  // reset zeros from matching an all-zero pattern. A load in the same cycle
  // drops the bit, so it also suppresses the match.
  always_comb begin
    next_hist = {hist[MAX_W-2:0], ser_in};
    next_fill = (fill >= LW'(MAX_W)) ? fill : fill + LW'(1);
    len_mask  = ~({MAX_W{1'b1}} << len);
    match     = 1'b0;
    if (ser_valid && !pat_load && (len != '0) && (next_fill >= len) &&
        (((next_hist ^ pat) & len_mask) == '0)) begin
      match = 1'b1;
    end
  end

  // Pattern registers, shift history and fill counter. A load wins over a
  // valid bit and restarts fill. In non-overlapping mode a match also
  // restarts fill, so the next match needs len fresh bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= DEF_PAT;
      len     <= LW'(DEF_LEN);
      det_out <= 1'b0;
    end else if (pat_load) begin
      pat     <= pat_in;
      len     <= (len_in > LW'(MAX_W)) ? LW'(MAX_W) : len_in;
      fill    <= '0;
      det_out <= 1'b0;
    end else if (ser_valid) begin
      hist    <= next_hist;
      fill    <= (match && !overlap) ? '0 : next_fill;
      det_out <= match;
    end else begin
      det_out <= 1'b0;
    end
  end

  // Saturating match counter. A clear takes priority over a match in the
  // same cycle; det_out still pulses for that match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  // Status flags, decoded directly from the registers.
  always_comb begin
    cnt_sat = &match_cnt;
    armed   = (fill >= len) && (len != '0);
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_det_prog
//
// Directed testbench for seq_det_prog. The main instance uses the default
// parameters. A second instance with a 2-bit counter shares the same
// stimulus and is checked for counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_det_prog;

  logic        clk;
  logic        reset;
  logic        ser_in;
  logic        ser_valid;
  logic        overlap;
  logic        pat_load;
  logic [15:0] pat_in;
  logic [4:0]  len_in;
  logic        cnt_clr;

  logic        det_out;
  logic [7:0]  match_cnt;
  logic        cnt_sat;
  logic        armed;

  logic        det_s;
  logic [1:0]  cnt_s;
  logic        sat_s;
  logic        armed_s;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        ser_in;
    logic        ser_valid;
    logic        overlap;
    logic        pat_load;
    logic [15:0] pat_in;
    logic [4:0]  len_in;
    logic        cnt_clr;
    logic        exp_det;
    logic [7:0]  exp_cnt;
    logic        exp_armed;
  } vec_t;

  vec_t vecs[$];

  seq_det_prog dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .cnt_clr   (cnt_clr),
    .det_out   (det_out),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat),
    .armed     (armed)
  );

  seq_det_prog #(.CNT_W(2)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .cnt_clr   (cnt_clr),
    .det_out   (det_s),
    .match_cnt (cnt_s),
    .cnt_sat   (sat_s),
    .armed     (armed_s)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds one table row.
  function automatic vec_t mk(input logic si, input logic sv, input logic ov,
                              input logic ld, input logic [15:0] pi,
                              input logic [4:0] li, input logic clr,
                              input logic ed, input logic [7:0] ec,
                              input logic ea);
    vec_t v;
    v.ser_in = si; v.ser_valid = sv; v.overlap = ov; v.pat_load = ld;
    v.pat_in = pi; v.len_in = li; v.cnt_clr = clr;
    v.exp_det = ed; v.exp_cnt = ec; v.exp_armed = ea;
    return v;
  endfunction

  // Drives one cycle of inputs, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic si, input logic sv,
                               input logic ld, input logic [15:0] pi,
                               input logic [4:0] li, input logic clr);
    ser_in    = si;
    ser_valid = sv;
    pat_load  = ld;
    pat_in    = pi;
    len_in    = li;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(b, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0);
  endtask

  task automatic loadPattern(input logic [15:0] p, input logic [4:0] l,
                             input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b1, p, l, clr);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [11:0] pat12;
    logic [17:0] stream6;

    reset = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; len_in = '0; cnt_clr = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset det_out", det_out, 0);
    checkOutput("reset match_cnt", match_cnt, 0);
    checkOutput("reset cnt_sat", cnt_sat, 0);
    checkOutput("reset armed", armed, 0);
    @(negedge clk);
    reset = 1'b1;

    // ---- test 1: default pattern 1110_1101_1011 ----
    $display("[TB] test 1: default pattern");
    overlap = 1'b1;
    pat12 = 12'hEDB;
    for (int i = 0; i < 12; i++) begin
      sendBit(pat12[11-i]);
      checkOutput($sformatf("t1 det bit %0d", i + 1), det_out, (i == 11));
      checkOutput($sformatf("t1 armed bit %0d", i + 1), armed, (i == 11));
    end
    checkOutput("t1 match_cnt", match_cnt, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0);
    checkOutput("t1 det after gap", det_out, 0);

    // ---- table: tests 2, 3 and load priority ----
    $display("[TB] table vectors");
    // pattern 1010 len 4, overlapping
    vecs.push_back(mk(0,0,1,1,16'h000A,5'd4,1, 0,0,0));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 1,1,1));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 0,1,1));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 1,2,1));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 0,2,1));
    // same stream, non-overlapping
    vecs.push_back(mk(0,0,0,1,16'h000A,5'd4,1, 0,0,0));
    vecs.push_back(mk(1,1,0,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 1,1,0));
    vecs.push_back(mk(1,1,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(1,1,0,0,16'h0,5'd0,0, 0,1,0));
    // all-zero pattern len 3, fill gating and valid gaps
    vecs.push_back(mk(0,0,0,1,16'h0000,5'd3,1, 0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 1,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(1,0,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(1,0,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(1,0,0,0,16'h0,5'd0,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0,5'd0,0, 1,2,0));
    // switch to overlapping with the zero pattern
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 0,2,0));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 0,2,0));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 1,3,1));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 1,4,1));
    vecs.push_back(mk(1,0,1,0,16'h0,5'd0,0, 0,4,1));
    // load coincident with a valid bit: the bit is dropped
    vecs.push_back(mk(0,1,1,1,16'h0003,5'd3,0, 0,4,0));
    vecs.push_back(mk(0,1,1,0,16'h0,5'd0,0, 0,4,0));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 0,4,0));
    vecs.push_back(mk(1,1,1,0,16'h0,5'd0,0, 1,5,1));

    foreach (vecs[i]) begin
      overlap = vecs[i].overlap;
      applyStimulus(vecs[i].ser_in, vecs[i].ser_valid, vecs[i].pat_load,
                    vecs[i].pat_in, vecs[i].len_in, vecs[i].cnt_clr);
      checkOutput($sformatf("vec %0d det", i), det_out, vecs[i].exp_det);
      checkOutput($sformatf("vec %0d cnt", i), match_cnt, vecs[i].exp_cnt);
      checkOutput($sformatf("vec %0d armed", i), armed, vecs[i].exp_armed);
    end

    // ---- test 4: counter saturation on the 2-bit instance ----
    $display("[TB] test 4: saturation");
    overlap = 1'b1;
    loadPattern(16'h0001, 5'd1, 1'b1);
    checkOutput("t4 small cnt cleared", cnt_s, 0);
    for (int i = 0; i < 5; i++) begin
      sendBit(1'b1);
      checkOutput($sformatf("t4 small det %0d", i), det_s, 1);
      checkOutput($sformatf("t4 small cnt %0d", i), cnt_s, (i < 3) ? i + 1 : 3);
      checkOutput($sformatf("t4 small sat %0d", i), sat_s, (i >= 2));
    end
    checkOutput("t4 big cnt", match_cnt, 5);
    checkOutput("t4 big sat", cnt_sat, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 5'd0, 1'b1);
    checkOutput("t4 clr+match det", det_s, 1);
    checkOutput("t4 clr+match small cnt", cnt_s, 0);
    checkOutput("t4 clr+match big cnt", match_cnt, 0);
    checkOutput("t4 clr small sat", sat_s, 0);
    sendBit(1'b1);
    checkOutput("t4 count after clr", cnt_s, 1);

    // ---- test 5: length clamp and zero length ----
    $display("[TB] test 5: length limits");
    loadPattern(16'hFFFF, 5'd20, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sendBit(1'b1);
      checkOutput($sformatf("t5 clamp det %0d", i), det_out, (i == 15));
      checkOutput($sformatf("t5 clamp armed %0d", i), armed, (i == 15));
    end
    sendBit(1'b1);
    checkOutput("t5 clamp overlap det", det_out, 1);
    checkOutput("t5 clamp cnt", match_cnt, 2);
    loadPattern(16'h0000, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      sendBit(1'b0);
      checkOutput($sformatf("t5 len0 det %0d", i), det_out, 0);
      checkOutput($sformatf("t5 len0 armed %0d", i), armed, 0);
    end
    checkOutput("t5 len0 cnt", match_cnt, 0);

    // ---- test 6: asynchronous reset mid-stream ----
    $display("[TB] test 6: async reset");
    loadPattern(16'h0001, 5'd1, 1'b0);
    repeat (4) sendBit(1'b1);
    checkOutput("t6 pre det", det_out, 1);
    checkOutput("t6 pre small sat", sat_s, 1);
    ser_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6 async det", det_out, 0);
    checkOutput("t6 async cnt", match_cnt, 0);
    checkOutput("t6 async small sat", sat_s, 0);
    checkOutput("t6 async armed", armed, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    overlap = 1'b1;
    // partial tail 011011 followed by the full default pattern
    stream6 = {6'b011011, 12'hEDB};
    for (int k = 0; k < 18; k++) begin
      sendBit(stream6[17-k]);
      checkOutput($sformatf("t6 det bit %0d", k + 1), det_out, (k == 17));
    end
    checkOutput("t6 final cnt", match_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
